// File: rtl/axi_demux_pkg.sv
`default_nettype none
// ============================================================================
// Package : axi_demux_pkg
// Brief   : Shared AW-FSM state type and outstanding-counter width helper.
// Rev     : 1.0  initial release
// ============================================================================
package axi_demux_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } aw_state_e;

  // Width needed to hold the values 0..max_trans inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_trans);
    return (max_trans > 0) ? $clog2(max_trans + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_demux_aw_w_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : axi_demux_aw_w_ctrl_if
// Brief     : AW/W/B handshake bundle between the slave port and master ports.
// Rev       : 1.0  initial release
// ============================================================================
interface axi_demux_aw_w_ctrl_if
  import axi_demux_pkg::*;
#(
  parameter int unsigned NoMstPorts = 32'd2,
  parameter int unsigned MaxTrans   = 32'd8,
  localparam int unsigned SelectWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1,
  localparam int unsigned CntWidth    = cnt_width(MaxTrans)
);

  logic                   slv_aw_valid_i;
  logic [SelectWidth-1:0] slv_aw_select_i;
  logic                   slv_aw_ready_o;
  logic [NoMstPorts-1:0]  mst_aw_valid_o;
  logic [NoMstPorts-1:0]  mst_aw_ready_i;
  logic                   slv_w_valid_i;
  logic                   slv_w_last_i;
  logic                   slv_w_ready_o;
  logic [NoMstPorts-1:0]  mst_w_valid_o;
  logic [NoMstPorts-1:0]  mst_w_ready_i;
  logic                   slv_b_done_i;
  logic [CntWidth-1:0]    outstanding_o;

  // The control block itself.
  modport slave (
    input  slv_aw_valid_i, slv_aw_select_i, mst_aw_ready_i,
    input  slv_w_valid_i, slv_w_last_i, mst_w_ready_i, slv_b_done_i,
    output slv_aw_ready_o, mst_aw_valid_o, slv_w_ready_o, mst_w_valid_o, outstanding_o
  );

  // The environment driving the control block.
  modport master (
    output slv_aw_valid_i, slv_aw_select_i, mst_aw_ready_i,
    output slv_w_valid_i, slv_w_last_i, mst_w_ready_i, slv_b_done_i,
    input  slv_aw_ready_o, mst_aw_valid_o, slv_w_ready_o, mst_w_valid_o, outstanding_o
  );

endinterface
`default_nettype wire

// File: rtl/fifo_v3.sv
`default_nettype none
// ============================================================================
// Module : fifo_v3
// Brief  : Circular-buffer FIFO with optional fall-through (common_cells API).
// Rev    : 1.0  initial release
// ============================================================================
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH-1:0] c_last_ptr = ADDR_DEPTH'(DEPTH - 1);
  localparam logic [ADDR_DEPTH:0]   c_depth    = (ADDR_DEPTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_DEPTH-1:0] r_rd_ptr, r_wr_ptr;
  logic [ADDR_DEPTH:0]   r_count;
  logic w_push, w_pop, w_bypass, w_store, w_take, w_unused_test;

  assign w_unused_test = testmode_i;

  assign full_o   = (r_count == c_depth);
  assign w_bypass = FALL_THROUGH && (r_count == '0) && push_i;
  assign empty_o  = (r_count == '0) && !w_bypass;
  assign data_o   = w_bypass ? data_i : r_mem[r_rd_ptr];

  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  // A bypassed entry popped in the same cycle never touches storage.
  assign w_store = w_push && !(w_bypass && w_pop);
  assign w_take  = w_pop && !w_bypass;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + ADDR_DEPTH'(1);
      if (w_take)  r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + ADDR_DEPTH'(1);
      if (w_store && !w_take)      r_count <= r_count + (ADDR_DEPTH + 1)'(1);
      else if (w_take && !w_store) r_count <= r_count - (ADDR_DEPTH + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_store) r_mem[r_wr_ptr] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/axi_demux_aw_w_ctrl.sv
`default_nettype none
// ============================================================================
// Module : axi_demux_aw_w_ctrl
// Brief  : AW routing FSM, W-route FIFO and outstanding-write counter.
// Config : AXI_DEMUX_W_FALLTHROUGH_EN makes the W-route FIFO fall-through.
// Rev    : 1.0  initial release
// ============================================================================
module axi_demux_aw_w_ctrl
  import axi_demux_pkg::*;
#(
  parameter int unsigned NoMstPorts = 32'd2,
  parameter int unsigned MaxWTrans  = 32'd4,
  parameter int unsigned MaxTrans   = 32'd8,
  localparam int unsigned SelectWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_i,
  axi_demux_aw_w_ctrl_if.slave bus
);

  typedef logic [SelectWidth-1:0] select_t;

  localparam int unsigned c_cnt_width = cnt_width(MaxTrans);
  localparam logic [c_cnt_width-1:0] c_max_trans = c_cnt_width'(MaxTrans);
`ifdef AXI_DEMUX_W_FALLTHROUGH_EN
  localparam bit c_fall_through = 1'b1;
`else
  localparam bit c_fall_through = 1'b0;
`endif

  aw_state_e               r_state, w_state_next;
  select_t                 r_sel, w_sel, w_w_head;
  logic [c_cnt_width-1:0]  r_outstanding;
  logic                    w_aw_en, w_aw_valid, w_aw_ready, w_aw_hs, w_lock;
  logic                    w_fifo_full, w_fifo_empty, w_w_ready, w_w_pop;
  logic [NoMstPorts-1:0]   w_mst_aw_valid, w_mst_w_valid;

  // A locked request keeps its port even if the enable condition drops.
  assign w_sel      = (r_state == LOCKED) ? r_sel : bus.slv_aw_select_i;
  assign w_aw_en    = rst_ni & ((r_state == LOCKED) |
                                (~w_fifo_full & (r_outstanding < c_max_trans)));
  assign w_aw_valid = w_aw_en & bus.slv_aw_valid_i;
  assign w_aw_ready = w_aw_en & bus.mst_aw_ready_i[w_sel];
  assign w_aw_hs    = w_aw_valid & w_aw_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_lock) r_sel <= bus.slv_aw_select_i;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_lock       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_aw_valid && !w_aw_ready) begin
          w_state_next = LOCKED;
          w_lock       = 1'b1;
        end
      end
      LOCKED: begin
        if (w_aw_hs) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_mst_aw_valid        = '0;
    w_mst_aw_valid[w_sel] = w_aw_valid;
    w_mst_w_valid         = '0;
    w_w_ready             = 1'b0;
    if (!w_fifo_empty) begin
      w_mst_w_valid[w_w_head] = bus.slv_w_valid_i;
      w_w_ready               = bus.mst_w_ready_i[w_w_head];
    end
  end

  assign bus.mst_aw_valid_o = w_mst_aw_valid;
  assign bus.slv_aw_ready_o = w_aw_ready;
  assign bus.mst_w_valid_o  = w_mst_w_valid;
  assign bus.slv_w_ready_o  = w_w_ready;
  assign bus.outstanding_o  = r_outstanding;

  assign w_w_pop = ~w_fifo_empty & bus.slv_w_valid_i & w_w_ready & bus.slv_w_last_i;

  fifo_v3 #(
    .FALL_THROUGH (c_fall_through),
    .DATA_WIDTH   (SelectWidth),
    .DEPTH        (MaxWTrans)
  ) i_w_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (test_i),
    .full_o     (w_fifo_full),
    .empty_o    (w_fifo_empty),
    .data_i     (w_sel),
    .push_i     (w_aw_hs),
    .data_o     (w_w_head),
    .pop_i      (w_w_pop)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
    end else if (w_aw_hs && !bus.slv_b_done_i) begin
      r_outstanding <= r_outstanding + c_cnt_width'(1);
    end else if (!w_aw_hs && bus.slv_b_done_i && (r_outstanding != '0)) begin
      r_outstanding <= r_outstanding - c_cnt_width'(1);
    end
  end

  // A B completion with nothing outstanding indicates an upstream protocol error.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.slv_b_done_i && !w_aw_hs) |-> (r_outstanding != '0));

endmodule
`default_nettype wire

// File: tb/tb_axi_demux_aw_w_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_demux_aw_w_ctrl
// Brief  : Directed and random checks of axi_demux_aw_w_ctrl against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_axi_demux_aw_w_ctrl;

  localparam int unsigned MAXW = 4;
  localparam int unsigned MAXT = 8;
`ifdef AXI_DEMUX_W_FALLTHROUGH_EN
  localparam bit FT = 1'b1;
`else
  localparam bit FT = 1'b0;
`endif

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic test_i = 1'b0;
  always #5 clk_i = ~clk_i;

  axi_demux_aw_w_ctrl_if #(.NoMstPorts(2), .MaxTrans(MAXT)) bus ();
  axi_demux_aw_w_ctrl_if #(.NoMstPorts(2), .MaxTrans(2))    bus2 ();

  axi_demux_aw_w_ctrl #(.NoMstPorts(2), .MaxWTrans(MAXW), .MaxTrans(MAXT)) dut (
    .clk_i (clk_i), .rst_ni (rst_ni), .test_i (test_i), .bus (bus)
  );
  axi_demux_aw_w_ctrl #(.NoMstPorts(2), .MaxWTrans(MAXW), .MaxTrans(2)) dut2 (
    .clk_i (clk_i), .rst_ni (rst_ni), .test_i (test_i), .bus (bus2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of routed ports, outstanding count, sticky pending port.
  int         q[$];
  int         outst;
  int         pend;
  int         m_sel;
  logic       m_hs, m_pop;
  logic [1:0] m_awv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    q.delete();
    outst = 0;
    pend  = -1;
  endtask

  task automatic drive(input logic awv, input logic sel, input logic [1:0] awr,
                       input logic wv, input logic wl, input logic [1:0] wr, input logic b);
    bus.slv_aw_valid_i  = awv;
    bus.slv_aw_select_i = sel;
    bus.mst_aw_ready_i  = awr;
    bus.slv_w_valid_i   = wv;
    bus.slv_w_last_i    = wl;
    bus.mst_w_ready_i   = wr;
    bus.slv_b_done_i    = b;
  endtask

  // Predict this cycle's outputs from the model, then compare after settling.
  task automatic eval(input string tag);
    logic       en, ex_awr, ex_wr, has_head;
    logic [1:0] ex_wv;
    int         head;
    en       = (pend >= 0) || (q.size() < MAXW && outst < MAXT);
    m_sel    = (pend >= 0) ? pend : int'(bus.slv_aw_select_i);
    m_awv    = (en && bus.slv_aw_valid_i) ? (2'b01 << m_sel) : 2'b00;
    ex_awr   = en && bus.mst_aw_ready_i[m_sel];
    m_hs     = bus.slv_aw_valid_i && ex_awr;
    has_head = (q.size() > 0) || (FT && m_hs);
    head     = (q.size() > 0) ? q[0] : m_sel;
    ex_wv    = (has_head && bus.slv_w_valid_i) ? (2'b01 << head) : 2'b00;
    ex_wr    = has_head && bus.mst_w_ready_i[head];
    m_pop    = bus.slv_w_valid_i && ex_wr && bus.slv_w_last_i;
    #2;
    chk({tag, ".aw_valid"}, bus.mst_aw_valid_o, m_awv);
    chk({tag, ".aw_ready"}, bus.slv_aw_ready_o, ex_awr);
    chk({tag, ".w_valid"},  bus.mst_w_valid_o,  ex_wv);
    chk({tag, ".w_ready"},  bus.slv_w_ready_o,  ex_wr);
    chk({tag, ".outst"},    bus.outstanding_o,  outst);
  endtask

  task automatic adv();
    if (m_hs) begin
      q.push_back(m_sel);
      pend = -1;
    end else if (m_awv != 2'b00) begin
      pend = m_sel;
    end
    if (m_pop) void'(q.pop_front());
    if (m_hs && !bus.slv_b_done_i) outst++;
    else if (!m_hs && bus.slv_b_done_i && outst > 0) outst--;
    @(posedge clk_i);
    #1;
  endtask

  task automatic step(input string tag);
    eval(tag);
    adv();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".aw_valid"}, bus.mst_aw_valid_o, 0);
    chk({tag, ".aw_ready"}, bus.slv_aw_ready_o, 0);
    chk({tag, ".w_valid"},  bus.mst_w_valid_o,  0);
    chk({tag, ".w_ready"},  bus.slv_w_ready_o,  0);
    chk({tag, ".outst"},    bus.outstanding_o,  0);
  endtask

  initial begin
    mreset();
    drive(0, 0, 2'b00, 0, 0, 2'b00, 0);
    bus2.slv_aw_valid_i = 0; bus2.slv_aw_select_i = 0; bus2.mst_aw_ready_i = 2'b00;
    bus2.slv_w_valid_i  = 0; bus2.slv_w_last_i    = 0; bus2.mst_w_ready_i  = 2'b00;
    bus2.slv_b_done_i   = 0;
    repeat (3) @(posedge clk_i);
    #1;
    // Everything requested while held in reset must stay silent.
    drive(1, 1, 2'b11, 1, 1, 2'b11, 0);
    #2;
    chk_reset_outputs("reset");
    drive(0, 0, 2'b00, 0, 0, 2'b00, 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Sticky select while the target port stalls.
    drive(1, 1, 2'b00, 0, 0, 2'b00, 0); eval("r31c1"); chk("r31c1.port", bus.mst_aw_valid_o, 2'b10); adv();
    drive(1, 0, 2'b00, 0, 0, 2'b00, 0); eval("r31c2"); chk("r31c2.port", bus.mst_aw_valid_o, 2'b10); adv();
    eval("r31c3"); chk("r31c3.port", bus.mst_aw_valid_o, 2'b10); adv();
    drive(1, 0, 2'b11, 0, 0, 2'b00, 0); eval("r31c4"); chk("r31c4.hs", bus.slv_aw_ready_o, 1); adv();
    drive(0, 0, 2'b00, 1, 1, 2'b11, 0); eval("r31w"); chk("r31w.port", bus.mst_w_valid_o, 2'b10); adv();
    drive(0, 0, 2'b00, 0, 0, 2'b00, 1); step("r31b");

    // Two AWs, then a 2-beat and a 1-beat burst.
    drive(1, 0, 2'b11, 0, 0, 2'b00, 0); step("r32aw0");
    drive(1, 1, 2'b11, 0, 0, 2'b00, 0); step("r32aw1");
    drive(0, 0, 2'b00, 1, 0, 2'b11, 0); eval("r32b0"); chk("r32b0.port", bus.mst_w_valid_o, 2'b01); adv();
    drive(0, 0, 2'b00, 1, 1, 2'b11, 0); eval("r32b1"); chk("r32b1.port", bus.mst_w_valid_o, 2'b01); adv();
    eval("r32b2"); chk("r32b2.port", bus.mst_w_valid_o, 2'b10); adv();
    eval("r32empty"); chk("r32empty.port", bus.mst_w_valid_o, 2'b00); adv();
    drive(0, 0, 2'b00, 0, 0, 2'b00, 1); step("r32bd0"); step("r32bd1");

    // Fill the W-route FIFO, then free one slot.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'($urandom), 2'b11, 0, 0, 2'b00, 0);
      step("r33fill");
    end
    drive(1, 1, 2'b11, 0, 0, 2'b00, 0); eval("r33stall"); chk("r33stall.rdy", bus.slv_aw_ready_o, 0); adv();
    drive(1, 1, 2'b11, 1, 1, 2'b11, 0); eval("r33pop");   chk("r33pop.rdy",   bus.slv_aw_ready_o, 0); adv();
    drive(1, 1, 2'b11, 0, 0, 2'b00, 0); eval("r33acc");   chk("r33acc.rdy",   bus.slv_aw_ready_o, 1); adv();
    drive(0, 0, 2'b00, 1, 1, 2'b11, 0); repeat (4) step("r33drain");
    drive(0, 0, 2'b00, 0, 0, 2'b00, 1); repeat (5) step("r33bd");

    // W beat alongside its own AW handshake.
    drive(1, 1, 2'b11, 1, 1, 2'b11, 0); eval("r35same");
    chk("r35same.port", bus.mst_w_valid_o, FT ? 2'b10 : 2'b00); adv();
    drive(0, 0, 2'b00, 1, 1, 2'b11, 0); eval("r35next");
    chk("r35next.port", bus.mst_w_valid_o, FT ? 2'b00 : 2'b10); adv();
    drive(0, 0, 2'b00, 0, 0, 2'b00, 1); step("r35bd");

    // Reset while locked with two routes queued.
    drive(1, 0, 2'b11, 0, 0, 2'b00, 0); step("r36aw0");
    drive(1, 1, 2'b11, 0, 0, 2'b00, 0); step("r36aw1");
    drive(1, 1, 2'b00, 0, 0, 2'b00, 0); eval("r36lock"); chk("r36lock.port", bus.mst_aw_valid_o, 2'b10); adv();
    drive(1, 1, 2'b11, 1, 1, 2'b11, 0);
    rst_ni = 1'b0;
    #2;
    chk_reset_outputs("r36rst");
    mreset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive(0, 0, 2'b00, 1, 1, 2'b11, 0); eval("r36w");    chk("r36w.port", bus.mst_w_valid_o, 2'b00); adv();
    drive(1, 0, 2'b00, 0, 0, 2'b00, 0); eval("r36idle"); chk("r36idle.port", bus.mst_aw_valid_o, 2'b01); adv();
    drive(1, 0, 2'b11, 0, 0, 2'b00, 0); step("r36hs");
    drive(0, 0, 2'b00, 1, 1, 2'b11, 1); step("r36clr");

    // Randomized traffic; AW valid is held while a request is pending.
    for (int i = 0; i < 400; i++) begin
      drive((pend >= 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom), 2'($urandom),
            1'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom),
            (outst > 0) ? ($urandom_range(0, 7) == 0) : 1'b0);
      step("rnd");
    end
    drive(0, 0, 2'b00, 0, 0, 2'b00, 0);

    // Outstanding limit of 2 with a B completion racing the third AW.
    bus2.slv_aw_valid_i = 1; bus2.slv_aw_select_i = 0; bus2.mst_aw_ready_i = 2'b11;
    #2; chk("r34aw0.rdy", bus2.slv_aw_ready_o, 1);
    @(posedge clk_i); #1;
    bus2.slv_aw_select_i = 1;
    #2; chk("r34aw1.rdy", bus2.slv_aw_ready_o, 1);
    @(posedge clk_i); #1;
    bus2.slv_b_done_i = 1;
    #2;
    chk("r34stall.rdy",   bus2.slv_aw_ready_o, 0);
    chk("r34stall.port",  bus2.mst_aw_valid_o, 2'b00);
    chk("r34stall.outst", bus2.outstanding_o,  2);
    @(posedge clk_i); #1;
    bus2.slv_b_done_i = 0;
    #2;
    chk("r34acc.outst", bus2.outstanding_o, 1);
    chk("r34acc.rdy",   bus2.slv_aw_ready_o, 1);
    @(posedge clk_i); #1;
    bus2.slv_aw_valid_i = 0;
    #2; chk("r34end.outst", bus2.outstanding_o, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
